audio_recorder: RTL and testbench
=================================

// Module: audio_recorder
// PURPOSE
//  Single-track audio loop recorder between the audio codec interface and the SDRAM controller.
//  Records one 32-bit sample per SAMPLE_INPUT_CLK rising edge into SDRAM at consecutive addresses.
//  Replays them in a loop, one per SAMPLE_OUTPUT_CLK rising edge. Clear zero-fills the recorded region.
// PARAMETERS
//  DATA_W    32          sample / SDRAM data width
//  ADDR_W    25          SDRAM word-address width; also the TIME/END_TIME width
//  MAX_ADDR  2**ADDR_W-1 last usable address; recording stops here (memory full)
// PORTS
//  Clk               in   1   system clock
//  Reset             in   1   synchronous, active-high
//  SAMPLE_INPUT_CLK  in   1   ADC sample strobe, async to Clk; a rising edge means a new INPUT_DATA sample
//  SAMPLE_OUTPUT_CLK in   1   DAC sample strobe, async to Clk; a rising edge requests the next OUTPUT_DATA sample
//  INPUT_DATA        in   32  sample to record
//  DO_RECORD         in   1   level: record mode
//  DO_PLAYBACK       in   1   level: playback mode
//  DO_CLEAR          in   1   level: clear mode
//  OUTPUT_DATA       out  32  current playback sample
//  TIME              out  25  current sample position (next address to access)
//  END_TIME          out  25  loop length in samples
//  RW_ACK            in   1   SDRAM controller acknowledges the current request
//  INIT_DONE         in   1   SDRAM initialised; no requests are issued before it is high
//  DATA_READ         in   32  SDRAM read data, valid while RW_ACK is high
//  DATA_ADDR         out  25  SDRAM address
//  DATA_WRITE        out  32  SDRAM write data
//  RW_READ           out  1   read request
//  RW_WRITE          out  1   write request
// BEHAVIOUR
//  Reset: OUTPUT_DATA=0, TIME=0, END_TIME=0, DATA_ADDR=0, DATA_WRITE=0, RW_READ=0, RW_WRITE=0, FSM=IDLE.
//  Sample strobes: each passes through a 2-flop synchroniser and an edge register. The edge pulse sets a pending flag.
//  - The FSM clears the pending flag when it starts serving it.
//  - An edge that arrives while the flag is already set is dropped.
//  Mode priority: CLEAR > RECORD > PLAYBACK. The mode is latched in IDLE only; a transaction in flight always completes.
//  Mode entry (rising edge of the selected mode):
//  - record: TIME=0, END_TIME=0.
//  - playback: TIME=0.
//  - clear: TIME=0.
//  FSM states: IDLE, WR_REQ, RD_REQ, CLR_REQ.
//  - Request outputs are held until the cycle RW_ACK=1. That cycle completes the transaction, drops the request and returns to IDLE.
//  - There is no wait for RW_ACK to fall; RW_ACK tied high gives a 1-cycle transaction plus a 1-cycle IDLE gap.
//  IDLE + record + input pending + INIT_DONE + TIME<=MAX_ADDR:
//  - Action: DATA_ADDR=TIME, DATA_WRITE=INPUT_DATA, RW_WRITE=1, go to WR_REQ.
//  - On ack: TIME++, END_TIME=TIME+1.
//  - Once TIME passes MAX_ADDR, further edges are ignored (full).
//  IDLE + playback + output pending + INIT_DONE + END_TIME!=0:
//  - Action: DATA_ADDR=TIME, RW_READ=1, go to RD_REQ.
//  - On ack: OUTPUT_DATA=DATA_READ and TIME = (TIME+1==END_TIME) ? 0 : TIME+1 (wrap-around).
//  - With END_TIME==0, pending edges are consumed and OUTPUT_DATA=0.
//  IDLE + clear + INIT_DONE + TIME<END_TIME:
//  - Action: write 0 at TIME back-to-back, independent of the strobes.
//  - On ack: TIME++.
//  - When TIME==END_TIME: END_TIME=0, TIME=0, clear done. It stays idle while DO_CLEAR remains high.
//  No mode active: no requests; TIME, END_TIME and OUTPUT_DATA hold.
//  Reset mid-transaction: the request drops immediately and all outputs return to reset values.
// CONFIGURATION
//  MONITOR_EN defined: in record mode, OUTPUT_DATA=INPUT_DATA on every input sample edge (live monitoring).
//  MONITOR_EN undefined: OUTPUT_DATA changes only on a playback read ack or on reset.
// STRUCTURE
//  Package recorder_pkg: DATA_W/ADDR_W localparams, typedef enum state_t {IDLE,WR_REQ,RD_REQ,CLR_REQ}, typedef enum mode_t {M_NONE,M_CLEAR,M_RECORD,M_PLAY}.
//  Sub-module strobe_edge_sync (2-flop sync + rising-edge pulse); instantiated twice.
// TESTING
//  1 Reset=1 for 1 cycle -> all outputs 0; hold INIT_DONE=0 with DO_RECORD=1 and strobes toggling -> RW_WRITE never asserted.
//  2 RW_ACK tied 1, INIT_DONE=1, DO_RECORD=1, INPUT_DATA counting, 3 input edges:
//    -> writes to addresses 0,1,2 carrying the INPUT_DATA value at each request
//    -> END_TIME=3, TIME=3.
//  3 Then DO_PLAYBACK=1, DATA_READ=32'hFABBDAAD, 7 output edges:
//    -> read addresses 0,1,2,0,1,2,0 (wrap-around)
//    -> OUTPUT_DATA=32'hFABBDAAD after the first ack; TIME=1 at the end.
//  4 DO_CLEAR=1 together with DO_PLAYBACK=1:
//    -> clear wins; zero writes to 0,1,2 back-to-back
//    -> then END_TIME=0, TIME=0, no further requests.
//  5 RW_ACK held 0 for 5 cycles during a write:
//    -> RW_WRITE, DATA_ADDR and DATA_WRITE stable for all 5 cycles; 2 input edges arriving meanwhile record only 1 extra sample.
//  6 Playback with END_TIME=0 -> no RW_READ, OUTPUT_DATA=0; with MONITOR_EN defined, record mode -> OUTPUT_DATA tracks INPUT_DATA.

Source files
------------

// File: rtl/recorder_pkg.sv
// ============================================================================
//  Module   : recorder_pkg
//  Purpose  : Shared widths, FSM/mode encodings and mode priority helper.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package recorder_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 25;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR_REQ  = 2'd1,
      RD_REQ  = 2'd2,
      CLR_REQ = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      M_NONE   = 2'd0,
      M_CLEAR  = 2'd1,
      M_RECORD = 2'd2,
      M_PLAY   = 2'd3
   } mode_t;

   // Clear outranks record, which outranks playback.
   function automatic mode_t select_mode(input logic clr, input logic rec, input logic play);
      mode_t m;
      if (clr)       m = M_CLEAR;
      else if (rec)  m = M_RECORD;
      else if (play) m = M_PLAY;
      else           m = M_NONE;
      return m;
   endfunction

endpackage

`default_nettype wire

// File: rtl/strobe_edge_sync.sv
// ============================================================================
//  Module   : strobe_edge_sync
//  Purpose  : Two-flop synchroniser for an async strobe plus a rising-edge pulse.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module strobe_edge_sync (
   input  logic Clk,
   input  logic Reset,
   input  logic strobe_i,
   output logic pulse_o
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= strobe_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign pulse_o = sync2_q & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/audio_recorder.sv
// ============================================================================
//  Module   : audio_recorder
//  Purpose  : Single-track loop recorder between codec strobes and SDRAM.
//             Define MONITOR_EN to echo INPUT_DATA on OUTPUT_DATA while recording.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module audio_recorder
   import recorder_pkg::*;
#(
   parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              SAMPLE_INPUT_CLK,
   input  logic              SAMPLE_OUTPUT_CLK,
   input  logic [DATA_W-1:0] INPUT_DATA,
   input  logic              DO_RECORD,
   input  logic              DO_PLAYBACK,
   input  logic              DO_CLEAR,
   output logic [DATA_W-1:0] OUTPUT_DATA,
   output logic [ADDR_W-1:0] TIME,
   output logic [ADDR_W-1:0] END_TIME,
   input  logic              RW_ACK,
   input  logic              INIT_DONE,
   input  logic [DATA_W-1:0] DATA_READ,
   output logic [ADDR_W-1:0] DATA_ADDR,
   output logic [DATA_W-1:0] DATA_WRITE,
   output logic              RW_READ,
   output logic              RW_WRITE
);

   state_t              state_q, state_d;
   mode_t               mode_q, mode_d, mode_sel;
   logic                in_pend_q, in_pend_d;
   logic                out_pend_q, out_pend_d;
   logic                full_q, full_d;
   logic [ADDR_W-1:0]   time_q, time_d;
   logic [ADDR_W-1:0]   end_q, end_d;
   logic [DATA_W-1:0]   out_q, out_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                rd_q, rd_d;
   logic                wr_q, wr_d;

   logic                in_pulse, out_pulse;
   logic                idle, entry;
   logic                wr_start, rd_start, clr_start;
   logic [ADDR_W:0]     time_inc;
   logic [ADDR_W-1:0]   time_sat, time_wrap;

   strobe_edge_sync u_in_sync (
      .Clk      (Clk),
      .Reset    (Reset),
      .strobe_i (SAMPLE_INPUT_CLK),
      .pulse_o  (in_pulse)
   );

   strobe_edge_sync u_out_sync (
      .Clk      (Clk),
      .Reset    (Reset),
      .strobe_i (SAMPLE_OUTPUT_CLK),
      .pulse_o  (out_pulse)
   );

   assign mode_sel  = select_mode(DO_CLEAR, DO_RECORD, DO_PLAYBACK);
   assign idle      = (state_q == IDLE);
   assign entry     = idle && (mode_sel != mode_q);
   assign wr_start  = idle && !entry && (mode_q == M_RECORD) && in_pend_q && INIT_DONE && !full_q;
   assign rd_start  = idle && !entry && (mode_q == M_PLAY) && out_pend_q && INIT_DONE
                      && (end_q != '0);
   assign clr_start = idle && !entry && (mode_q == M_CLEAR) && INIT_DONE && (time_q < end_q);

   // Record at the very last address saturates rather than wrapping to zero.
   assign time_inc  = {1'b0, time_q} + (ADDR_W+1)'(1);
   assign time_sat  = time_inc[ADDR_W] ? {ADDR_W{1'b1}} : time_inc[ADDR_W-1:0];
   assign time_wrap = (time_inc == {1'b0, end_q}) ? '0 : time_inc[ADDR_W-1:0];

   always_ff @(posedge Clk) begin : p_state_reg
      if (Reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin : p_next_state
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (wr_start)       state_d = WR_REQ;
            else if (rd_start)  state_d = RD_REQ;
            else if (clr_start) state_d = CLR_REQ;
         end
         WR_REQ, RD_REQ, CLR_REQ: begin
            if (RW_ACK) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin : p_outputs
      mode_d     = mode_q;
      in_pend_d  = in_pend_q | in_pulse;
      out_pend_d = out_pend_q | out_pulse;
      full_d     = full_q;
      time_d     = time_q;
      end_d      = end_q;
      out_d      = out_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rd_d       = rd_q;
      wr_d       = wr_q;

      case (state_q)
         IDLE: begin
            if (entry) begin
               // Samples strobed before the mode began are stale.
               mode_d     = mode_sel;
               in_pend_d  = 1'b0;
               out_pend_d = 1'b0;
               case (mode_sel)
                  M_RECORD: begin
                     time_d = '0;
                     end_d  = '0;
                     full_d = 1'b0;
                  end
                  M_PLAY, M_CLEAR: time_d = '0;
                  default: ;
               endcase
            end else begin
               case (mode_q)
                  M_RECORD: begin
                     out_pend_d = 1'b0;
                     if (in_pend_q && full_q) begin
                        in_pend_d = 1'b0;
                     end else if (wr_start) begin
                        in_pend_d = 1'b0;
                        addr_d    = time_q;
                        wdata_d   = INPUT_DATA;
                        wr_d      = 1'b1;
                     end
                  end
                  M_PLAY: begin
                     in_pend_d = 1'b0;
                     if (out_pend_q && (end_q == '0)) begin
                        out_pend_d = 1'b0;
                        out_d      = '0;
                     end else if (rd_start) begin
                        out_pend_d = 1'b0;
                        addr_d     = time_q;
                        rd_d       = 1'b1;
                     end
                  end
                  M_CLEAR: begin
                     in_pend_d  = 1'b0;
                     out_pend_d = 1'b0;
                     if (clr_start) begin
                        addr_d  = time_q;
                        wdata_d = '0;
                        wr_d    = 1'b1;
                     end else if (time_q >= end_q) begin
                        time_d = '0;
                        end_d  = '0;
                     end
                  end
                  default: begin
                     in_pend_d  = 1'b0;
                     out_pend_d = 1'b0;
                  end
               endcase
            end
         end
         WR_REQ: begin
            if (RW_ACK) begin
               wr_d   = 1'b0;
               time_d = time_sat;
               end_d  = time_sat;
               if (time_q == MAX_ADDR) full_d = 1'b1;
            end
         end
         RD_REQ: begin
            if (RW_ACK) begin
               rd_d   = 1'b0;
               out_d  = DATA_READ;
               time_d = time_wrap;
            end
         end
         CLR_REQ: begin
            if (RW_ACK) begin
               wr_d   = 1'b0;
               time_d = time_inc[ADDR_W-1:0];
            end
         end
         default: ;
      endcase

`ifdef MONITOR_EN
      if ((mode_q == M_RECORD) && in_pulse) out_d = INPUT_DATA;
`else
`endif
   end

   always_ff @(posedge Clk) begin : p_data_reg
      if (Reset) begin
         mode_q     <= M_NONE;
         in_pend_q  <= 1'b0;
         out_pend_q <= 1'b0;
         full_q     <= 1'b0;
         time_q     <= '0;
         end_q      <= '0;
         out_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
      end else begin
         mode_q     <= mode_d;
         in_pend_q  <= in_pend_d;
         out_pend_q <= out_pend_d;
         full_q     <= full_d;
         time_q     <= time_d;
         end_q      <= end_d;
         out_q      <= out_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
      end
   end

   assign OUTPUT_DATA = out_q;
   assign TIME        = time_q;
   assign END_TIME    = end_q;
   assign DATA_ADDR   = addr_q;
   assign DATA_WRITE  = wdata_q;
   assign RW_READ     = rd_q;
   assign RW_WRITE    = wr_q;

endmodule

`default_nettype wire

// File: tb/tb_audio_recorder.sv
// ============================================================================
//  Module   : tb_audio_recorder
//  Purpose  : Scoreboard bench for audio_recorder with a mock SDRAM.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_audio_recorder;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        SAMPLE_INPUT_CLK, SAMPLE_OUTPUT_CLK;
   logic [31:0] INPUT_DATA;
   logic        DO_RECORD, DO_PLAYBACK, DO_CLEAR;
   logic [31:0] OUTPUT_DATA;
   logic [24:0] TIME, END_TIME;
   logic        RW_ACK, INIT_DONE;
   logic [31:0] DATA_READ;
   logic [24:0] DATA_ADDR;
   logic [31:0] DATA_WRITE;
   logic        RW_READ, RW_WRITE;
   logic        ack_en;

   always #5 Clk = ~Clk;

   audio_recorder dut (
      .Clk               (Clk),
      .Reset             (Reset),
      .SAMPLE_INPUT_CLK  (SAMPLE_INPUT_CLK),
      .SAMPLE_OUTPUT_CLK (SAMPLE_OUTPUT_CLK),
      .INPUT_DATA        (INPUT_DATA),
      .DO_RECORD         (DO_RECORD),
      .DO_PLAYBACK       (DO_PLAYBACK),
      .DO_CLEAR          (DO_CLEAR),
      .OUTPUT_DATA       (OUTPUT_DATA),
      .TIME              (TIME),
      .END_TIME          (END_TIME),
      .RW_ACK            (RW_ACK),
      .INIT_DONE         (INIT_DONE),
      .DATA_READ         (DATA_READ),
      .DATA_ADDR         (DATA_ADDR),
      .DATA_WRITE        (DATA_WRITE),
      .RW_READ           (RW_READ),
      .RW_WRITE          (RW_WRITE)
   );

   typedef struct {
      bit          wr;
      logic [24:0] addr;
      logic [31:0] data;
   } txn_t;

   txn_t        exp_q[$];
   logic [31:0] rec[$];       // reference loop contents, index = address
   int          play_pos;
   logic [31:0] mem [0:63];   // mock SDRAM
   int          tests = 0;
   int          fails = 0;
   int          req_cnt = 0;

   assign RW_ACK    = ack_en;
   assign DATA_READ = mem[DATA_ADDR[5:0]];

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Monitor: pops the scoreboard on every acknowledged request.
   initial begin : monitor
      txn_t        t;
      logic        out_chk;
      logic [31:0] out_exp;
      out_chk = 1'b0;
      out_exp = '0;
      forever begin
         @(negedge Clk);
         if (out_chk) begin
            check("play_output", {32'h0, OUTPUT_DATA}, {32'h0, out_exp});
            out_chk = 1'b0;
         end
         if (!Reset && RW_ACK && (RW_WRITE || RW_READ)) begin
            req_cnt++;
            if (exp_q.size() == 0) begin
               check("unexpected_req", 64'd1, 64'd0);
               $display("  unexpected request wr=%0b rd=%0b addr=%0h", RW_WRITE, RW_READ, DATA_ADDR);
            end else begin
               t = exp_q.pop_front();
               check("req_kind", {63'h0, RW_WRITE}, {63'h0, t.wr});
               check("req_addr", {39'h0, DATA_ADDR}, {39'h0, t.addr});
               if (t.wr) begin
                  check("wr_data", {32'h0, DATA_WRITE}, {32'h0, t.data});
                  mem[DATA_ADDR[5:0]] = DATA_WRITE;
               end else begin
                  out_exp = t.data;
                  out_chk = 1'b1;
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      fails++;
      $display("FAIL watchdog: got timeout, required completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic in_edge(input logic [31:0] d);
      INPUT_DATA       = d;
      SAMPLE_INPUT_CLK = 1'b1;
      tick(2);
      SAMPLE_INPUT_CLK = 1'b0;
      tick(2);
   endtask

   task automatic out_edge();
      SAMPLE_OUTPUT_CLK = 1'b1;
      tick(2);
      SAMPLE_OUTPUT_CLK = 1'b0;
      tick(2);
   endtask

   task automatic record_sample(input logic [31:0] d);
      exp_q.push_back('{wr: 1'b1, addr: 25'(rec.size()), data: d});
      rec.push_back(d);
      in_edge(d);
      tick(6);
   endtask

   task automatic play_sample();
      if (rec.size() != 0) begin
         exp_q.push_back('{wr: 1'b0, addr: 25'(play_pos), data: rec[play_pos]});
         play_pos = (play_pos + 1) % rec.size();
      end
      out_edge();
      tick(6);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick(1);
      check(name, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      tick(3);
   endtask

   initial begin : stimulus
      logic [31:0] base, d0, d1, d2;
      logic [24:0] stall_addr;
      int          n, reqs;

      for (int i = 0; i < 64; i++) mem[i] = '0;
      Reset = 1'b1;
      SAMPLE_INPUT_CLK = 1'b0;
      SAMPLE_OUTPUT_CLK = 1'b0;
      INPUT_DATA = '0;
      DO_RECORD = 1'b1;
      DO_PLAYBACK = 1'b0;
      DO_CLEAR = 1'b0;
      INIT_DONE = 1'b0;
      ack_en = 1'b1;
      play_pos = 0;
      tick(1);
      Reset = 1'b0;
      @(negedge Clk);
      check("rst_output", {32'h0, OUTPUT_DATA}, 64'd0);
      check("rst_time", {39'h0, TIME}, 64'd0);
      check("rst_end", {39'h0, END_TIME}, 64'd0);
      check("rst_addr", {39'h0, DATA_ADDR}, 64'd0);
      check("rst_wdata", {32'h0, DATA_WRITE}, 64'd0);
      check("rst_req", {62'h0, RW_READ, RW_WRITE}, 64'd0);

      // No requests while SDRAM is uninitialised.
      for (int i = 0; i < 3; i++) begin
         in_edge($urandom);
         out_edge();
      end
      tick(6);
      check("noinit_reqs", 64'(req_cnt), 64'd0);
      check("noinit_write", {63'h0, RW_WRITE}, 64'd0);

      DO_RECORD = 1'b0;
      INIT_DONE = 1'b1;
      tick(4);
      DO_RECORD = 1'b1;
      tick(4);

      // Record three counting samples.
      base = $urandom;
      for (int i = 0; i < 3; i++) record_sample(base + 32'(i));
      drain("rec_drain");
      check("rec_end", {39'h0, END_TIME}, 64'(rec.size()));
      check("rec_time", {39'h0, TIME}, 64'(rec.size()));

      // Playback loops over the recording.
      DO_RECORD = 1'b0;
      DO_PLAYBACK = 1'b1;
      tick(4);
      play_pos = 0;
      for (int i = 0; i < 7; i++) play_sample();
      drain("play_drain");
      check("play_time", {39'h0, TIME}, 64'(play_pos));

      // Clear beats playback and zero-fills the loop.
      reqs = req_cnt;
      for (int i = 0; i < rec.size(); i++) exp_q.push_back('{wr: 1'b1, addr: 25'(i), data: 32'h0});
      n = rec.size();
      rec.delete();
      DO_CLEAR = 1'b1;
      tick(2);
      drain("clr_drain");
      tick(10);
      check("clr_end", {39'h0, END_TIME}, 64'd0);
      check("clr_time", {39'h0, TIME}, 64'd0);
      check("clr_reqs", 64'(req_cnt - reqs), 64'(n));

      // Playback of an empty loop issues no reads and zeroes the output.
      DO_CLEAR = 1'b0;
      tick(4);
      reqs = req_cnt;
      for (int i = 0; i < 3; i++) play_sample();
      drain("empty_drain");
      check("empty_reqs", 64'(req_cnt - reqs), 64'd0);
      check("empty_output", {32'h0, OUTPUT_DATA}, 64'd0);

      // Re-record a random number of samples.
      DO_PLAYBACK = 1'b0;
      tick(3);
      DO_RECORD = 1'b1;
      tick(4);
      n = $urandom_range(2, 5);
      for (int i = 0; i < n; i++) record_sample($urandom);
      drain("rec2_drain");
`ifdef MONITOR_EN
      check("monitor_output", {32'h0, OUTPUT_DATA}, {32'h0, rec[rec.size()-1]});
`else
      check("hold_output", {32'h0, OUTPUT_DATA}, 64'd0);
`endif

      // Stalled write: request held; two edges meanwhile add one sample.
      ack_en = 1'b0;
      d0 = $urandom;
      d1 = $urandom;
      d2 = $urandom;
      stall_addr = 25'(rec.size());
      exp_q.push_back('{wr: 1'b1, addr: stall_addr, data: d0});
      rec.push_back(d0);
      in_edge(d0);
      for (int i = 0; i < 20 && !RW_WRITE; i++) tick(1);
      check("stall_req", {63'h0, RW_WRITE}, 64'd1);
      fork
         begin
            in_edge(d1);
            in_edge(d2);
         end
         begin
            for (int i = 0; i < 5; i++) begin
               @(negedge Clk);
               check("stall_write", {63'h0, RW_WRITE}, 64'd1);
               check("stall_addr", {39'h0, DATA_ADDR}, {39'h0, stall_addr});
               check("stall_data", {32'h0, DATA_WRITE}, {32'h0, d0});
            end
         end
      join
      tick(4);
      exp_q.push_back('{wr: 1'b1, addr: 25'(rec.size()), data: d2});
      rec.push_back(d2);
      ack_en = 1'b1;
      drain("stall_drain");
      check("stall_end", {39'h0, END_TIME}, 64'(rec.size()));

      // Random-length playback of the new loop.
      DO_RECORD = 1'b0;
      DO_PLAYBACK = 1'b1;
      tick(4);
      play_pos = 0;
      n = $urandom_range(5, 12);
      for (int i = 0; i < n; i++) play_sample();
      drain("play2_drain");
      check("play2_time", {39'h0, TIME}, 64'(play_pos));
      check("play2_end", {39'h0, END_TIME}, 64'(rec.size()));

      // Reset while a read is outstanding.
      ack_en = 1'b0;
      out_edge();
      for (int i = 0; i < 20 && !RW_READ; i++) tick(1);
      check("midrst_req", {63'h0, RW_READ}, 64'd1);
      Reset = 1'b1;
      tick(1);
      Reset = 1'b0;
      ack_en = 1'b1;
      @(negedge Clk);
      check("midrst_read", {63'h0, RW_READ}, 64'd0);
      check("midrst_end", {39'h0, END_TIME}, 64'd0);
      check("midrst_output", {32'h0, OUTPUT_DATA}, 64'd0);
      tick(10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
